seq_scan_arbiter: RTL and testbench
===================================

# seq_scan_arbiter

Shares one serial `0111` pattern detector among NREQ parallel requesters. Each requester presents a WIDTH-bit word. The block grants requesters round-robin, shifts the granted word MSB-first through the detector, and counts matches. It returns the match count and requester id over a valid/ready response port. It sits between the parallel-word producers and the serial detection datapath, and is the only client of the detector.

## Interface
- NREQ, 4: number of requesters (2..8).
- WIDTH, 8: bits per word (4..32).
- clk  in  1  clock. All registers are on the rising edge.
- reset  in  1  asynchronous, active-high.
- req_valid  in  NREQ  bit i high means requester i has a word.
- req_data  in  NREQ*WIDTH  word of requester i is at [i*WIDTH +: WIDTH].
- req_ready  out  NREQ  one-hot or zero. A word is accepted when req_valid[i] and req_ready[i] are both high.
- resp_valid  out  1  response available.
- resp_ready  in  1  consumer accepts the response.
- resp_id  out  $clog2(NREQ)  requester whose word was scanned.
- resp_count  out  $clog2(WIDTH+1)  number of `0111` matches in the word.
- busy  out  1  high in SCAN and RESP.

## Operation
- The controller FSM has three states: IDLE, SCAN and RESP. Reset state is IDLE.
- **IDLE**
  - Grant goes to the first i with req_valid[i] set, searching from (last_grant+1) mod NREQ upward with wrap.
  - req_ready[grant] is driven combinationally in IDLE only, and only when some req_valid is high.
  - On acceptance, the controller:
    - latches the word into a shift register, latches resp_id, and sets last_grant to the grant;
    - clears the match counter and forces the detector to S0;
    - loads bit counter = WIDTH-1 and moves to SCAN.
- **SCAN**
  - Each cycle, the shift register MSB drives detector input d, and the register shifts left.
  - When the detector match is high, the match counter increments.
  - When bit counter = 0, the FSM moves to RESP. Otherwise the bit counter decrements.
- **RESP**
  - resp_valid = 1. resp_id and resp_count are held stable.
  - When resp_ready is high, the FSM moves to IDLE. No new word is accepted in that same cycle.
- **Detector (Mealy)**
  - Transitions:
    - S0: d=0 goes to S1, else stays S0.
    - S1: d=1 goes to S2, else stays S1.
    - S2: d=1 goes to S3, else goes to S1.
    - S3: d=1 goes to S0, else goes to S1.
  - match = (state == S3) & d.
  - A sync clear forces S0. Matches never span two words.
- **Width rules**
  - The match counter is $clog2(WIDTH+1) bits wide and cannot overflow.
  - last_grant resets to NREQ-1, so requester 0 has first priority after reset.
- **Boundary conditions**
  - req_valid changes while not granted: no effect. req_ready stays 0 outside IDLE.
  - A requester dropping valid in the grant cycle: no transfer. Arbitration is re-evaluated the next cycle.
  - resp_ready held low: stay in RESP indefinitely with outputs held. Requests are not accepted.
  - Reset at any point: the FSM, detector, counters and last_grant return to reset values immediately. An in-flight word is discarded and no response is produced.

## Timing
- Reset values:
  - req_ready = 0 (all bits), resp_valid = 0, busy = 0;
  - resp_id = 0, resp_count = 0, last_grant = NREQ-1.
- Latency:
  - Accept at edge T, meaning the transfer is sampled at edge T.
  - Bits are scanned at edges T+1 through T+WIDTH.
  - resp_valid is high from cycle T+WIDTH, i.e. WIDTH cycles after the accept edge.
  - resp_count includes the match from the final bit.
- Throughput: one word per WIDTH+2 cycles at best (accept, WIDTH scan cycles, one response cycle with resp_ready=1).
- resp_valid, resp_id, resp_count and busy are registered. req_ready is combinational from state and req_valid.

## Structure
- Package `seq_scan_pkg` holds two typedefs:
  - `det_state_t`: logic [1:0] enum S0..S3;
  - `ctl_state_t`: IDLE, SCAN, RESP.
- Sub-module `seq_detect_core`:
  - ports: clk, reset, clear, d, match;
  - contents: the Mealy detector above, with the synchronous clear.
- The round-robin arbiter is inline, built as rotate, priority-encode, un-rotate.

## Test plan
- Reset, then req_valid=0001, data0=8'b0111_0111:
  - req_ready=0001 for 1 cycle;
  - resp_valid 8 cycles after the accept edge, resp_id=0, resp_count=2.
- data=8'hFF, then 8'h00, then 8'b0011_1000 → resp_count=0, 0, 1 respectively.
- req_valid=1111 held, resp_ready=1 → grant order 0,1,2,3,0 with matching resp_id.
- resp_ready=0 for 10 cycles in RESP:
  - resp_valid, resp_id and resp_count are stable;
  - req_ready=0;
  - after resp_ready=1, IDLE and the next grant follow.
- Word 8'b0111_0000 followed by 8'b1110_0000 → counts 1 then 0. No cross-word match.
- Reset asserted at the 4th scan cycle:
  - busy=0 and resp_valid=0 immediately;
  - after release, requester 0 has priority and the next word scans correctly.

Source files
------------

// File: rtl/seq_scan_pkg.sv
// Shared types for the round-robin arbiter in front of the serial 0111 detector.
package seq_scan_pkg;

  typedef enum logic [1:0] {
    S0 = 2'd0,
    S1 = 2'd1,
    S2 = 2'd2,
    S3 = 2'd3
  } det_state_t;

  typedef enum logic [1:0] {
    IDLE = 2'd0,
    SCAN = 2'd1,
    RESP = 2'd2
  } ctl_state_t;

endpackage

// File: rtl/seq_detect_core.sv
// Mealy detector for the serial pattern 0111; clear restarts it so matches never span words.
module seq_detect_core
  import seq_scan_pkg::*;
(
  input  logic clk,
  input  logic reset,
  input  logic clear,
  input  logic d,
  output logic match
);

  det_state_t state, state_nx;

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= S0;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    if (clear) begin
      state_nx = S0;
    end else begin
      case (state)
        S0:      state_nx = d ? S0 : S1;
        S1:      state_nx = d ? S2 : S1;
        S2:      state_nx = d ? S3 : S1;
        S3:      state_nx = d ? S0 : S1;
        default: state_nx = S0;
      endcase
    end
  end

  assign match = (state == S3) && d;

endmodule

// File: rtl/seq_scan_arbiter.sv
// Round-robin front end that feeds one requester word at a time, MSB first, through the
// shared 0111 detector and returns the match count with the requester id.
module seq_scan_arbiter
  import seq_scan_pkg::*;
#(
  parameter  int NREQ  = 4,
  parameter  int WIDTH = 8,
  localparam int IDW   = $clog2(NREQ),
  localparam int CW    = $clog2(WIDTH + 1)
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [NREQ-1:0]       req_valid,
  input  logic [NREQ*WIDTH-1:0] req_data,
  output logic [NREQ-1:0]       req_ready,
  output logic                  resp_valid,
  input  logic                  resp_ready,
  output logic [IDW-1:0]        resp_id,
  output logic [CW-1:0]         resp_count,
  output logic                  busy
);

  localparam int            BW       = $clog2(WIDTH);
  localparam logic [IDW-1:0] LAST_IDX = IDW'(NREQ - 1);
  localparam logic [IDW:0]   NREQ_V   = (IDW + 1)'(NREQ);

  ctl_state_t       state, state_nx;
  logic [WIDTH-1:0] shreg;
  logic [BW-1:0]    bit_cnt;
  logic [CW-1:0]    match_cnt;
  logic [IDW-1:0]   last_grant;
  logic [IDW-1:0]   start, off, grant;
  logic [IDW:0]     sum;
  logic [2*NREQ-1:0] dbl;
  logic [NREQ-1:0]  rot;
  logic             found;
  logic             any_valid;
  logic             accept;
  logic             det_match;
  logic [WIDTH-1:0] word_sel;

  // Round robin: rotate so the search starts after last_grant, take the lowest set bit,
  // then rotate the index back.
  always_comb begin
    start = (last_grant == LAST_IDX) ? '0 : last_grant + 1'b1;
    dbl   = {req_valid, req_valid};
    rot   = dbl[start +: NREQ];
    off   = '0;
    found = 1'b0;
    for (int i = 0; i < NREQ; i++) begin
      if (!found && rot[i]) begin
        off   = IDW'(i);
        found = 1'b1;
      end
    end
    sum = {1'b0, start} + {1'b0, off};
    if (sum >= NREQ_V) sum = sum - NREQ_V;
    grant = sum[IDW-1:0];
  end

  always_comb begin
    word_sel = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant == IDW'(i)) word_sel = req_data[i*WIDTH +: WIDTH];
    end
  end

  // Handshakes: a transfer happens on a rising edge where valid and ready are both high.
  // req_ready depends only on state and req_valid; resp_valid holds until resp_ready.
  assign any_valid = |req_valid;

  always_comb begin
    req_ready = '0;
    if (state == IDLE && any_valid) req_ready[grant] = 1'b1;
  end

  assign accept = |(req_valid & req_ready);

  always_ff @(posedge clk or posedge reset) begin
    if (reset) state <= IDLE;
    else       state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      IDLE:    if (accept) state_nx = SCAN;
      SCAN:    if (bit_cnt == '0) state_nx = RESP;
      RESP:    if (resp_ready) state_nx = IDLE;
      default: state_nx = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      shreg      <= '0;
      bit_cnt    <= '0;
      match_cnt  <= '0;
      resp_id    <= '0;
      last_grant <= LAST_IDX;
      resp_valid <= 1'b0;
      busy       <= 1'b0;
    end else begin
      resp_valid <= (state_nx == RESP);
      busy       <= (state_nx != IDLE);
      case (state)
        IDLE: begin
          if (accept) begin
            shreg      <= word_sel;
            resp_id    <= grant;
            last_grant <= grant;
            match_cnt  <= '0;
            bit_cnt    <= BW'(WIDTH - 1);
          end
        end
        SCAN: begin
          shreg <= shreg << 1;
          if (det_match) match_cnt <= match_cnt + 1'b1;
          if (bit_cnt != '0) bit_cnt <= bit_cnt - 1'b1;
        end
        default: ;
      endcase
    end
  end

  assign resp_count = match_cnt;

  seq_detect_core u_det (
    .clk   (clk),
    .reset (reset),
    .clear (accept),
    .d     (shreg[WIDTH-1]),
    .match (det_match)
  );

endmodule

// File: tb/tb_seq_scan_arbiter.sv
// Bench for seq_scan_arbiter: directed cases plus random traffic against a reference model.
module tb_seq_scan_arbiter;

  localparam int NREQ  = 4;
  localparam int WIDTH = 8;
  localparam int IDW   = $clog2(NREQ);
  localparam int CW    = $clog2(WIDTH + 1);

  logic                  clk;
  logic                  reset;
  logic [NREQ-1:0]       req_valid;
  logic [NREQ*WIDTH-1:0] req_data;
  logic [NREQ-1:0]       req_ready;
  logic                  resp_valid;
  logic                  resp_ready;
  logic [IDW-1:0]        resp_id;
  logic [CW-1:0]         resp_count;
  logic                  busy;

  int checks   = 0;
  int failures = 0;
  int m_last   = NREQ - 1;
  logic [IDW+CW-1:0] exp_q[$];

  seq_scan_arbiter #(.NREQ(NREQ), .WIDTH(WIDTH)) dut (
    .clk        (clk),
    .reset      (reset),
    .req_valid  (req_valid),
    .req_data   (req_data),
    .req_ready  (req_ready),
    .resp_valid (resp_valid),
    .resp_ready (resp_ready),
    .resp_id    (resp_id),
    .resp_count (resp_count),
    .busy       (busy)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog obs=timeout exp=finish");
    $fatal(1, "watchdog expired");
  end

  // reference model: count 0111 windows in the word, scan requesters after the last grant
  function automatic int model_count(input logic [WIDTH-1:0] w);
    int c = 0;
    for (int i = WIDTH - 1; i >= 3; i--) begin
      if (w[i -: 4] == 4'b0111) c++;
    end
    return c;
  endfunction

  function automatic int model_grant(input logic [NREQ-1:0] m, input int last);
    for (int k = 1; k <= NREQ; k++) begin
      if (m[(last + k) % NREQ]) return (last + k) % NREQ;
    end
    return -1;
  endfunction

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp_v);
    checks++;
    if (obs !== exp_v) begin
      failures++;
      $display("FAIL %s obs=%0h exp=%0h", tag, obs, exp_v);
    end
  endtask

  // driver tasks; each starts and ends just after a falling edge
  task automatic start_word(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data,
                            output int g);
    logic [NREQ-1:0] exp_ready;
    req_valid = mask;
    req_data  = data;
    #1;
    g = model_grant(mask, m_last);
    exp_ready = '0;
    if (g >= 0) exp_ready[g] = 1'b1;
    check("req_ready_idle", req_ready, exp_ready);
    @(posedge clk);
    if (g >= 0) begin
      m_last = g;
      exp_q.push_back({IDW'(g), CW'(model_count(data[g*WIDTH +: WIDTH]))});
    end
    @(negedge clk);
    if (g >= 0) begin
      check("busy_scan", busy, 1);
      check("req_ready_scan", req_ready, 0);
    end else begin
      check("busy_no_req", busy, 0);
    end
  endtask

  task automatic finish_word(input int stall);
    int n;
    logic [IDW+CW-1:0] exp_v;
    n = 0;
    while (!resp_valid && n < 40) begin
      @(negedge clk);
      n++;
    end
    check("resp_latency", n, WIDTH);
    exp_v = (exp_q.size() > 0) ? exp_q.pop_front() : '1;
    check("resp_id", resp_id, exp_v[IDW+CW-1:CW]);
    check("resp_count", resp_count, exp_v[CW-1:0]);
    for (int s = 0; s < stall; s++) begin
      @(negedge clk);
      check("stall_valid", resp_valid, 1);
      check("stall_id", resp_id, exp_v[IDW+CW-1:CW]);
      check("stall_count", resp_count, exp_v[CW-1:0]);
      check("stall_ready", req_ready, 0);
    end
    resp_ready = 1'b1;
    @(negedge clk);
    resp_ready = 1'b0;
    check("resp_done", {busy, resp_valid}, 0);
  endtask

  task automatic one_word(input logic [NREQ-1:0] mask, input logic [NREQ*WIDTH-1:0] data,
                          input int stall);
    int g;
    start_word(mask, data, g);
    if (g >= 0) finish_word(stall);
  endtask

  initial begin
    int g;
    req_valid  = '0;
    req_data   = '0;
    resp_ready = 1'b0;
    reset      = 1'b1;
    repeat (2) @(negedge clk);
    check("rst_req_ready", req_ready, 0);
    check("rst_resp_valid", resp_valid, 0);
    check("rst_busy", busy, 0);
    check("rst_resp_id", resp_id, 0);
    check("rst_resp_count", resp_count, 0);
    reset = 1'b0;
    @(negedge clk);

    one_word(4'b0001, {24'h0, 8'b0111_0111}, 0);
    one_word(4'b0001, {24'h0, 8'hFF}, 0);
    one_word(4'b0001, {24'h0, 8'h00}, 0);
    one_word(4'b0001, {24'h0, 8'b0011_1000}, 0);
    one_word(4'b0001, {24'h0, 8'b0111_0000}, 0);
    one_word(4'b0001, {24'h0, 8'b1110_0000}, 0);

    // a requester drops valid before the edge: nothing is transferred
    req_valid = 4'b0010;
    #1;
    check("drop_ready", req_ready, 4'b0010);
    #2;
    req_valid = '0;
    @(negedge clk);
    check("drop_busy", busy, 0);

    // reset in the middle of a scan
    start_word(4'b0001, {24'h0, 8'b0111_0111}, g);
    repeat (3) @(negedge clk);
    reset     = 1'b1;
    req_valid = '0;
    #1;
    check("midrst_busy", busy, 0);
    check("midrst_valid", resp_valid, 0);
    check("midrst_ready", req_ready, 0);
    check("midrst_count", resp_count, 0);
    exp_q.delete();
    m_last = NREQ - 1;
    @(negedge clk);
    reset = 1'b0;
    @(negedge clk);
    check("midrst_no_resp", resp_valid, 0);

    // all requesters valid: round robin 0,1,2,3,0
    for (int k = 0; k < 5; k++) one_word(4'b1111, $urandom, 0);

    one_word(4'b1111, $urandom, 10);
    one_word(4'b0110, $urandom, 0);

    for (int k = 0; k < 24; k++) begin
      one_word(4'($urandom_range(0, 15)), $urandom, $urandom_range(0, 3));
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
